// File: rtl/bsg_counter_sched_pkg.sv
// Shared types for the round-robin timeslice scheduler.
package bsg_counter_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } sched_state_e;

  localparam int unsigned DEFAULT_WIDTH = 16;

endpackage

// File: rtl/bsg_counter_sched_rr_pick.sv
// Combinational round-robin picker: first requester strictly after ptr_i, wrapping.
module bsg_counter_sched_rr_pick #(
  parameter int els_p = 4,
  parameter int idx_w = (els_p > 1) ? $clog2(els_p) : 1
) (
  input  logic [els_p-1:0] req_i,
  input  logic [idx_w-1:0] ptr_i,
  output logic [idx_w-1:0] idx_o,
  output logic             v_o
);

  int               j;
  logic [idx_w-1:0] jj;

  // Walk from the farthest offset down so the nearest requester is written last.
  always_comb begin
    idx_o = '0;
    v_o   = 1'b0;
    j     = 0;
    jj    = '0;
    for (int off = els_p; off >= 1; off--) begin
      j  = (int'(ptr_i) + off) % els_p;
      jj = idx_w'(j);
      if (req_i[jj]) begin
        idx_o = jj;
        v_o   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bsg_counter_down_rr_sched.sv
// Round-robin owner of a shared down-counter timeslice; back-to-back slices
// without an idle bubble when BSG_COUNTER_SCHED_B2B_EN is defined.
module bsg_counter_down_rr_sched
  import bsg_counter_sched_pkg::*;
#(
  parameter int els_p   = 4,
  parameter int width_p = DEFAULT_WIDTH
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic [els_p-1:0]         req_i,
  input  logic [els_p*width_p-1:0] len_i,
  input  logic                     pause_i,
  input  logic                     abort_i,
  output logic [els_p-1:0]         grant_o,
  output logic                     busy_o,
  output logic [width_p-1:0]       count_r_o,
  output logic [els_p-1:0]         done_o,
  output logic                     aborted_o
);

  localparam int idx_w = $clog2(els_p);

  sched_state_e       state_r;
  logic [idx_w-1:0]   idx_r, ptr_r;
  logic [width_p-1:0] cnt_r;
  logic               abort_r;

  logic [idx_w-1:0]   win_idx;
  logic               win_v;
  logic [width_p-1:0] win_len;

  bsg_counter_sched_rr_pick #(.els_p(els_p), .idx_w(idx_w)) pick (
    .req_i (req_i),
    .ptr_i (ptr_r),
    .idx_o (win_idx),
    .v_o   (win_v)
  );

  assign win_len = len_i[win_idx*width_p +: width_p];

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r <= ST_IDLE;
      cnt_r   <= '0;
      idx_r   <= '0;
      ptr_r   <= idx_w'(els_p - 1);
      abort_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (win_v) begin
            idx_r   <= win_idx;
            ptr_r   <= win_idx;
            cnt_r   <= win_len;
            abort_r <= 1'b0;
            state_r <= (win_len == '0) ? ST_DONE : ST_RUN;
          end
        end
        ST_RUN: begin
          // A RUN slice always starts nonzero, so the ==1 test keeps us off zero.
          if (abort_i) begin
            cnt_r   <= '0;
            abort_r <= 1'b1;
            state_r <= ST_DONE;
          end else if (!pause_i) begin
            if (cnt_r == width_p'(1)) begin
              cnt_r   <= '0;
              state_r <= ST_DONE;
            end else begin
              cnt_r <= cnt_r - width_p'(1);
            end
          end
        end
        ST_DONE: begin
          abort_r <= 1'b0;
`ifdef BSG_COUNTER_SCHED_B2B_EN
          // Pointer already sits on the finishing owner, so it is re-picked only when alone.
          if (win_v) begin
            idx_r   <= win_idx;
            ptr_r   <= win_idx;
            cnt_r   <= win_len;
            state_r <= (win_len == '0) ? ST_DONE : ST_RUN;
          end else begin
            state_r <= ST_IDLE;
          end
`else
          state_r <= ST_IDLE;
`endif
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    grant_o = '0;
    done_o  = '0;
    if (state_r != ST_IDLE) grant_o[idx_r] = 1'b1;
    if (state_r == ST_DONE) done_o[idx_r]  = 1'b1;
  end

  assign busy_o    = (state_r != ST_IDLE);
  assign aborted_o = (state_r == ST_DONE) && abort_r;
  assign count_r_o = cnt_r;

endmodule

// File: tb/tb_bsg_counter_down_rr_sched.sv
// Random + directed bench for bsg_counter_down_rr_sched against a slice-level model.
module tb_bsg_counter_down_rr_sched;

`ifdef BSG_COUNTER_SCHED_B2B_EN
  localparam bit B2B = 1'b1;
`else
  localparam bit B2B = 1'b0;
`endif

  localparam int N = 4;
  localparam int W = 16;

  logic           clk_i = 1'b0;
  logic           reset_n_i;
  logic [N-1:0]   req_i;
  logic [N*W-1:0] len_i;
  logic           pause_i, abort_i;
  logic [N-1:0]   grant_o, done_o;
  logic           busy_o, aborted_o;
  logic [W-1:0]   count_r_o;

  int checks = 0;
  int errors = 0;

  // slice-level model: owner (-1 = none), remaining ticks, ending flag, abort flag
  int owner, mcnt, mptr;
  bit mdone, mab;

  bsg_counter_down_rr_sched #(.els_p(N), .width_p(W)) dut (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .req_i     (req_i),
    .len_i     (len_i),
    .pause_i   (pause_i),
    .abort_i   (abort_i),
    .grant_o   (grant_o),
    .busy_o    (busy_o),
    .count_r_o (count_r_o),
    .done_o    (done_o),
    .aborted_o (aborted_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      if (errors < 30) $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int off = 1; off <= N; off++)
      if (r[(p + off) % N]) return (p + off) % N;
    return -1;
  endfunction

  task automatic model_reset();
    owner = -1; mcnt = 0; mptr = N - 1; mdone = 0; mab = 0;
  endtask

  task automatic model_load(input int w);
    owner = w;
    mptr  = w;
    mcnt  = int'(len_i[w*W +: W]);
    mdone = (mcnt == 0);
    mab   = 0;
  endtask

  task automatic model_tick();
    int w;
    w = pick(req_i, mptr);
    if (owner < 0) begin
      if (w >= 0) model_load(w);
    end else if (mdone) begin
      if (B2B && w >= 0) model_load(w);
      else begin owner = -1; mdone = 0; mab = 0; end
    end else if (abort_i) begin
      mcnt = 0; mdone = 1; mab = 1;
    end else if (!pause_i) begin
      mcnt--;
      if (mcnt == 0) mdone = 1;
    end
  endtask

  task automatic cmp_all();
    chk("grant",   32'(grant_o),   (owner < 0) ? 32'd0 : (32'd1 << owner));
    chk("busy",    32'(busy_o),    32'(owner >= 0));
    chk("count",   32'(count_r_o), 32'(mcnt));
    chk("done",    32'(done_o),    (owner >= 0 && mdone) ? (32'd1 << owner) : 32'd0);
    chk("aborted", 32'(aborted_o), 32'(owner >= 0 && mdone && mab));
    chk("onehot",  32'($onehot0(grant_o)), 32'd1);
  endtask

  // Compare at negedge, drive, let the DUT and model advance one edge.
  task automatic step(input logic [N-1:0] r, input bit p, input bit a);
    cmp_all();
    req_i = r; pause_i = p; abort_i = a;
    @(posedge clk_i);
    model_tick();
    @(negedge clk_i);
  endtask

  task automatic set_len(input int i, input int v);
    len_i[i*W +: W] = W'(v);
  endtask

  initial begin
    reset_n_i = 1'b0; req_i = '0; len_i = '0; pause_i = 1'b0; abort_i = 1'b0;
    model_reset();
    repeat (3) @(negedge clk_i);
    cmp_all();
    reset_n_i = 1'b1;

    // single requester, len 3
    set_len(0, 3);
    step(4'b0001, 0, 0);
    repeat (4) step(4'b0000, 0, 0);
    repeat (2) step(4'b0000, 0, 0);

    // all requesting, len 1: rotation 0,1,2,3,0
    for (int i = 0; i < N; i++) set_len(i, 1);
    repeat (14) step(4'b1111, 0, 0);
    repeat (4) step(4'b0000, 0, 0);

    // zero-length slice
    set_len(2, 0);
    step(4'b0100, 0, 0);
    repeat (3) step(4'b0000, 0, 0);

    // pause then abort
    set_len(1, 10);
    step(4'b0010, 0, 0);
    repeat (2) step(4'b0000, 0, 0);
    repeat (4) step(4'b0000, 1, 0);
    for (int k = 0; k < 20 && mcnt != 5; k++) step(4'b0000, 0, 0);
    chk("pre_abort_cnt", 32'(mcnt), 32'd5);
    step(4'b0000, 0, 1);
    repeat (3) step(4'b0000, 0, 0);

    // async reset mid-slice at count 7
    step(4'b0010, 0, 0);
    for (int k = 0; k < 20 && mcnt != 7; k++) step(4'b0000, 0, 0);
    chk("pre_reset_cnt", 32'(mcnt), 32'd7);
    #2 reset_n_i = 1'b0;
    model_reset();
    #1 cmp_all();
    @(negedge clk_i);
    cmp_all();
    reset_n_i = 1'b1;
    step(4'b0010, 0, 0);
    chk("post_reset_owner", 32'(grant_o), 32'b0010);
    repeat (14) step(4'b0000, 0, 0);

    // maximum length, no wrap
    set_len(3, 16'hFFFF);
    step(4'b1000, 0, 0);
    for (int k = 0; k < 65540 && !(owner >= 0 && mdone); k++) step(4'b0000, 0, 0);
    chk("long_done", 32'(done_o), 32'b1000);
    repeat (3) step(4'b0000, 0, 0);

    // random traffic
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < N; i++) set_len(i, $urandom_range(0, 5));
      step(N'($urandom_range(0, 15)), ($urandom_range(0, 4) == 0), ($urandom_range(0, 19) == 0));
    end
    cmp_all();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bsg_counter_down_rr_sched.md
Name: bsg_counter_down_rr_sched

Overview:
- Round-robin scheduler that shares one loadable down-counter (timeslice timer) among els_p requesters.
- Each requester presents a slice length. The winner is granted exclusively, the counter is loaded with its length and counts down to zero, then a per-requester done pulse fires.
- Sits in front of shared resources (DMA engine, memory port, test harness) that need time-multiplexed ownership with bounded hold times.

Parameters:
- els_p, 4, number of requesters (>=2)
- width_p, 16, counter / slice-length width

Ports:
- clk_i  in  1  clock
- reset_n_i  in  1  asynchronous active-low reset
- req_i  in  els_p  per-requester request, level-sensitive
- len_i  in  els_p*width_p  packed slice lengths; requester i at bits [i*width_p +: width_p]
- pause_i  in  1  freezes countdown while asserted
- abort_i  in  1  terminates the current slice early
- grant_o  out  els_p  one-hot owner of the resource
- busy_o  out  1  a slice is active (RUN or DONE)
- count_r_o  out  width_p  current counter value
- done_o  out  els_p  one-cycle one-hot pulse at slice end
- aborted_o  out  1  qualifies done_o: slice ended by abort_i

Behaviour:
- Reset (async, reset_n_i=0):
  - state=IDLE; counter=0.
  - Round-robin pointer=els_p-1, so index 0 has first priority.
  - All outputs 0 immediately; a slice in progress is dropped with no done_o.
- States: IDLE, RUN, DONE (encoded in 2 bits).
- IDLE:
  - If |req_i, pick the first requesting index strictly after the pointer, wrapping els_p-1 -> 0.
  - Register the winner idx; load counter with len_i[idx]; pointer<=idx.
  - Next state is RUN if len!=0, DONE if len==0.
  - With no request, remain in IDLE.
- RUN:
  - grant_o=onehot(idx); busy_o=1.
  - Each cycle with pause_i=0: if counter==1, counter<=0 and go to DONE; else counter<=counter-1.
  - pause_i=1: counter and state hold.
  - abort_i=1 (overrides pause_i): counter<=0; go to DONE; set internal abort flag.
- DONE:
  - grant_o held; done_o=onehot(idx) for exactly one cycle; aborted_o=abort flag.
  - Next state is IDLE; abort flag cleared.
- Latency: request sampled in IDLE at cycle 0 -> grant_o high cycles 1..L+1 (L RUN cycles plus DONE, with no pause) -> done_o at cycle L+1 -> IDLE at L+2 -> next grant at L+3.
- Ownership rules:
  - req_i deasserting mid-slice is ignored; the slice completes.
  - len_i is sampled only at load.
  - abort_i and pause_i are ignored in IDLE and DONE.
- Arithmetic: counter never underflows. The maximum length 2^width_p-1 is legal.
- Invariants: grant_o is always one-hot or zero; done_o is never asserted outside DONE.

Optional Feature:
- Macro: BSG_COUNTER_SCHED_B2B_EN
- Defined: DONE performs arbitration itself when |req_i. The winner is loaded in the same cycle, going to RUN or DONE directly with no IDLE bubble, and the next grant begins the cycle after done_o.
  - The requester whose slice is ending may be re-picked only if no other requester is active, because the pointer equals its index.
  - grant_o switches owners cycle-to-cycle with no zero gap.
- Undefined: DONE always returns to IDLE, giving one idle cycle between slices.

Decomposition:
- Shared package bsg_counter_sched_pkg:
  - state enum typedef (IDLE/RUN/DONE)
  - default width constant
- Sub-module bsg_counter_sched_rr_pick (combinational):
  - inputs: req vector and pointer
  - outputs: winner index and valid
  - reusable by other arbiters
- Counter, FSM and pointer registers stay in the top module.

Test Plan:
- Reset release, req_i=4'b0001, len0=3 -> grant_o=0001 for cycles 1-4, count_r_o 3,2,1,0, done_o[0] at cycle 4, busy_o low at cycle 5.
- req_i=4'b1111 held, all len=1 -> grants in order 0,1,2,3,0; each grant 2 cycles with a 1-cycle gap (0-cycle gap with B2B_EN).
- len2=0, req_i=4'b0100 -> RUN skipped; done_o[2] pulses cycle 1; count_r_o stays 0.
- len1=10, pause_i high for 4 cycles mid-slice, then abort_i at count 5 -> count holds during pause, drops to 0 on abort; done_o[1] with aborted_o=1 next cycle.
- Assert reset_n_i low mid-RUN with count 7 -> grant_o, busy_o, count_r_o clear asynchronously; no done_o; after release, req_i=4'b0010 is granted as index 1.
- len3=16'hFFFF -> completes after 65535 RUN cycles with no wrap; done_o[3] asserted.
